// File: rtl/ex_stage_if.sv
// Execute-stage bus: decoded instruction from ID, hazard-unit controls,
// WB write port for forwarding, and the registered EX/MEM and ID/EX outputs.
interface ex_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              hold;
  logic              bubble;
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_alu_src;
  logic [3:0]        id_alu_ctrl;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd_addr;
  logic [DATA_W-1:0] wb_data;
  logic              idex_mem_read;
  logic [REG_AW-1:0] idex_rd_addr;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [REG_AW-1:0] ex_rd_addr;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic              ex_zero;

  modport master (
    output hold, bubble, id_valid, id_rs_data, id_rt_data, id_imm, id_alu_src,
           id_alu_ctrl, id_rs_addr, id_rt_addr, id_rd_addr, id_reg_write,
           id_mem_read, id_mem_write, wb_reg_write, wb_rd_addr, wb_data,
    input  idex_mem_read, idex_rd_addr, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_rd_addr, ex_alu_result, ex_store_data, ex_zero
  );

  modport slave (
    input  hold, bubble, id_valid, id_rs_data, id_rt_data, id_imm, id_alu_src,
           id_alu_ctrl, id_rs_addr, id_rt_addr, id_rd_addr, id_reg_write,
           id_mem_read, id_mem_write, wb_reg_write, wb_rd_addr, wb_data,
    output idex_mem_read, idex_rd_addr, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_rd_addr, ex_alu_result, ex_store_data, ex_zero
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ID/EX and EX/MEM pipeline registers, rs/rt operand
// forwarding from EX/MEM and WB, and the 4-bit-coded ALU.
module ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [3:0]        alu_ctrl;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } idex_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [REG_AW-1:0] rd_addr;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic              zero;
  } exmem_t;

  idex_t             idex_q, idex_in;
  exmem_t            exmem_q;
  logic [DATA_W-1:0] fwd_a, fwd_b, op_b, alu_res;
  logic              ex_fwd_ok, wb_fwd_ok;

  always_comb begin
    idex_in           = '0;
    idex_in.valid     = 1'b1;
    idex_in.alu_src   = bus.id_alu_src;
    idex_in.reg_write = bus.id_reg_write;
    idex_in.mem_read  = bus.id_mem_read;
    idex_in.mem_write = bus.id_mem_write;
    idex_in.alu_ctrl  = bus.id_alu_ctrl;
    idex_in.rs_addr   = bus.id_rs_addr;
    idex_in.rt_addr   = bus.id_rt_addr;
    idex_in.rd_addr   = bus.id_rd_addr;
    idex_in.rs_data   = bus.id_rs_data;
    idex_in.rt_data   = bus.id_rt_data;
    idex_in.imm       = bus.id_imm;
  end

  // A load in EX/MEM has no result yet; the hazard unit stalls those cases.
  assign ex_fwd_ok = exmem_q.reg_write && !exmem_q.mem_read && (exmem_q.rd_addr != '0);
  assign wb_fwd_ok = bus.wb_reg_write && (bus.wb_rd_addr != '0);

  always_comb begin
    fwd_a = idex_q.rs_data;
    if (ex_fwd_ok && exmem_q.rd_addr == idex_q.rs_addr)
      fwd_a = exmem_q.alu_result;
    else if (wb_fwd_ok && bus.wb_rd_addr == idex_q.rs_addr)
      fwd_a = bus.wb_data;

    fwd_b = idex_q.rt_data;
    if (ex_fwd_ok && exmem_q.rd_addr == idex_q.rt_addr)
      fwd_b = exmem_q.alu_result;
    else if (wb_fwd_ok && bus.wb_rd_addr == idex_q.rt_addr)
      fwd_b = bus.wb_data;
  end

  assign op_b = idex_q.alu_src ? idex_q.imm : fwd_b;

  always_comb begin
    alu_res = '0;
    unique case (idex_q.alu_ctrl)
      4'b0000: alu_res = fwd_a & op_b;
      4'b0001: alu_res = fwd_a | op_b;
      4'b0010: alu_res = fwd_a + op_b;
      4'b0110: alu_res = fwd_a - op_b;
      4'b0100: alu_res = fwd_a ^ op_b;
      4'b1100: alu_res = ~(fwd_a | op_b);
      4'b0111: alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // During hold the operand data fields re-latch the forwarded values so a
  // WB-stage source retiring mid-hold is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
    end else if (bus.hold) begin
      idex_q.rs_data <= fwd_a;
      idex_q.rt_data <= fwd_b;
    end else if (bus.bubble || !bus.id_valid) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_q <= '0;
    end else if (!bus.hold) begin
      exmem_q.valid      <= idex_q.valid;
      exmem_q.reg_write  <= idex_q.reg_write;
      exmem_q.mem_read   <= idex_q.mem_read;
      exmem_q.mem_write  <= idex_q.mem_write;
      exmem_q.rd_addr    <= idex_q.rd_addr;
      exmem_q.alu_result <= alu_res;
      exmem_q.store_data <= fwd_b;
      exmem_q.zero       <= (alu_res == '0);
    end
  end

  assign bus.idex_mem_read = idex_q.mem_read;
  assign bus.idex_rd_addr  = idex_q.rd_addr;
  assign bus.ex_valid      = exmem_q.valid;
  assign bus.ex_reg_write  = exmem_q.reg_write;
  assign bus.ex_mem_read   = exmem_q.mem_read;
  assign bus.ex_mem_write  = exmem_q.mem_write;
  assign bus.ex_rd_addr    = exmem_q.rd_addr;
  assign bus.ex_alu_result = exmem_q.alu_result;
  assign bus.ex_store_data = exmem_q.store_data;
  assign bus.ex_zero       = exmem_q.zero;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, forwarding priority,
// hold/bubble behaviour and asynchronous reset.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] ctrl, input logic [4:0] rs, input logic [31:0] rsd,
                       input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                       input logic src, input logic [31:0] imm);
    bus.id_valid     = 1'b1;
    bus.id_alu_ctrl  = ctrl;
    bus.id_rs_addr   = rs;
    bus.id_rs_data   = rsd;
    bus.id_rt_addr   = rt;
    bus.id_rt_data   = rtd;
    bus.id_rd_addr   = rd;
    bus.id_alu_src   = src;
    bus.id_imm       = imm;
    bus.id_reg_write = 1'b1;
    bus.id_mem_read  = 1'b0;
    bus.id_mem_write = 1'b0;
  endtask

  task automatic nop();
    issue(4'b0010, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 32'h0);
    bus.id_valid     = 1'b0;
    bus.id_reg_write = 1'b0;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    bus.wb_reg_write = we;
    bus.wb_rd_addr   = rd;
    bus.wb_data      = d;
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    issue(ctrl, 5'd10, a, 5'd11, b, 5'd9, 1'b0, 32'h0);
    tick();
    nop();
    tick();
    chk(tag, bus.ex_alu_result, exp);
  endtask

  initial begin
    bus.hold = 1'b0;
    bus.bubble = 1'b0;
    nop();
    set_wb(1'b0, 5'd0, 32'h0);

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.ex_valid, 32'h0);
    chk("rst_result", bus.ex_alu_result, 32'h0);
    chk("rst_zero", bus.ex_zero, 32'h0);
    chk("rst_idex_rd", bus.idex_rd_addr, 32'h0);
    chk("rst_idex_mr", bus.idex_mem_read, 32'h0);
    #6 rst_n = 1'b1;

    // Basic ADD r3(5) + r4(7)
    issue(4'b0010, 5'd3, 32'h5, 5'd4, 32'h7, 5'd6, 1'b0, 32'h0);
    tick();
    chk("add_idex_rd", bus.idex_rd_addr, 32'd6);
    nop();
    tick();
    chk("add_result", bus.ex_alu_result, 32'hC);
    chk("add_zero", bus.ex_zero, 32'h0);
    chk("add_valid", bus.ex_valid, 32'h1);
    chk("add_rd", bus.ex_rd_addr, 32'd6);

    // Back-to-back EX/MEM forward: r1 = 0x10+0x20, r2 = r1 - 0x30
    issue(4'b0010, 5'd2, 32'h10, 5'd3, 32'h20, 5'd1, 1'b0, 32'h0);
    tick();
    issue(4'b0110, 5'd1, 32'hDEAD, 5'd4, 32'h30, 5'd2, 1'b0, 32'h0);
    tick();
    chk("fwd_ex_producer", bus.ex_alu_result, 32'h30);
    nop();
    tick();
    chk("fwd_ex_result", bus.ex_alu_result, 32'h0);
    chk("fwd_ex_zero", bus.ex_zero, 32'h1);

    // Same dependency via the WB port
    issue(4'b0010, 5'd2, 32'h10, 5'd3, 32'h20, 5'd1, 1'b0, 32'h0);
    tick();
    nop();
    tick();
    issue(4'b0110, 5'd1, 32'hDEAD, 5'd4, 32'h30, 5'd2, 1'b0, 32'h0);
    set_wb(1'b1, 5'd1, 32'h30);
    tick();
    nop();
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    chk("fwd_wb_result", bus.ex_alu_result, 32'h0);
    chk("fwd_wb_zero", bus.ex_zero, 32'h1);

    // EX/MEM (0xAA) beats WB (0xBB) on r5; rt also forwarded into store data
    issue(4'b0001, 5'd0, 32'hAA, 5'd0, 32'h0, 5'd5, 1'b0, 32'h0);
    tick();
    issue(4'b0010, 5'd5, 32'h11, 5'd5, 32'h22, 5'd7, 1'b1, 32'h100);
    set_wb(1'b1, 5'd5, 32'hBB);
    tick();
    nop();
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    chk("prio_result", bus.ex_alu_result, 32'h1AA);
    chk("prio_store", bus.ex_store_data, 32'hAA);

    // Same scenario on r0: never forwarded
    issue(4'b0001, 5'd0, 32'hAA, 5'd0, 32'h0, 5'd0, 1'b0, 32'h0);
    tick();
    issue(4'b0010, 5'd0, 32'h11, 5'd0, 32'h22, 5'd7, 1'b1, 32'h100);
    set_wb(1'b1, 5'd0, 32'hBB);
    tick();
    nop();
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    chk("r0_result", bus.ex_alu_result, 32'h111);
    chk("r0_store", bus.ex_store_data, 32'h22);

    // ALU corner cases
    alu_vec("slt_signed", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1);
    alu_vec("slt_false", 4'b0111, 32'h1, 32'hFFFF_FFFF, 32'h0);
    alu_vec("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    alu_vec("nor", 4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFF);
    alu_vec("undef", 4'b1111, 32'h1234, 32'h5678, 32'h0);
    chk("undef_zero", bus.ex_zero, 32'h1);
    alu_vec("and", 4'b0000, 32'hF0F0, 32'hFF00, 32'hF000);
    alu_vec("or", 4'b0001, 32'hF0F0, 32'h0F00, 32'hFFF0);
    alu_vec("xor", 4'b0100, 32'hF0F0, 32'hFF00, 32'h0FF0);
    alu_vec("sub_wrap", 4'b0110, 32'h0, 32'h1, 32'hFFFF_FFFF);

    // Hold for 3 cycles while the WB producer of r8 retires
    issue(4'b0001, 5'd0, 32'h70, 5'd0, 32'h07, 5'd12, 1'b0, 32'h0);
    tick();
    issue(4'b0010, 5'd8, 32'h0, 5'd0, 32'h1, 5'd9, 1'b0, 32'h0);
    set_wb(1'b1, 5'd8, 32'h50);
    tick();
    issue(4'b0100, 5'd0, 32'hF0, 5'd0, 32'h0F, 5'd13, 1'b0, 32'h0);
    bus.hold = 1'b1;
    tick();
    chk("hold1_result", bus.ex_alu_result, 32'h77);
    set_wb(1'b0, 5'd0, 32'h0);
    bus.bubble = 1'b1;
    tick();
    chk("hold2_result", bus.ex_alu_result, 32'h77);
    chk("hold_bubble_idex_rd", bus.idex_rd_addr, 32'd9);
    bus.bubble = 1'b0;
    tick();
    chk("hold3_rd", bus.ex_rd_addr, 32'd12);
    bus.hold = 1'b0;
    tick();
    chk("hold_fwd_result", bus.ex_alu_result, 32'h51);
    chk("hold_fwd_rd", bus.ex_rd_addr, 32'd9);
    nop();
    tick();
    chk("after_hold_result", bus.ex_alu_result, 32'hFF);
    chk("after_hold_rd", bus.ex_rd_addr, 32'd13);

    // Bubble alone
    issue(4'b0010, 5'd0, 32'h3, 5'd0, 32'h4, 5'd14, 1'b0, 32'h0);
    bus.bubble = 1'b1;
    tick();
    chk("bubble_idex_rd", bus.idex_rd_addr, 32'd0);
    bus.bubble = 1'b0;
    nop();
    tick();
    chk("bubble_valid", bus.ex_valid, 32'h0);
    chk("bubble_reg_write", bus.ex_reg_write, 32'h0);

    // Asynchronous reset mid-stream
    issue(4'b0010, 5'd0, 32'h100, 5'd0, 32'h0, 5'd15, 1'b1, 32'h23);
    tick();
    issue(4'b0010, 5'd0, 32'h0, 5'd0, 32'h0, 5'd16, 1'b1, 32'h4);
    bus.id_mem_read = 1'b1;
    tick();
    chk("pre_rst_result", bus.ex_alu_result, 32'h123);
    chk("pre_rst_idex_mr", bus.idex_mem_read, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.ex_valid, 32'h0);
    chk("arst_result", bus.ex_alu_result, 32'h0);
    chk("arst_reg_write", bus.ex_reg_write, 32'h0);
    chk("arst_rd", bus.ex_rd_addr, 32'h0);
    chk("arst_idex_mr", bus.idex_mem_read, 32'h0);
    chk("arst_idex_rd", bus.idex_rd_addr, 32'h0);
    #2 rst_n = 1'b1;
    issue(4'b0010, 5'd0, 32'h2, 5'd0, 32'h3, 5'd4, 1'b0, 32'h0);
    tick();
    nop();
    tick();
    chk("restart_result", bus.ex_alu_result, 32'h5);
    chk("restart_valid", bus.ex_valid, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
